// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI-lite master: bus response codes, master FSM
// state encoding, CPU request size codes and the address-alignment helper.
// Optional feature macro used by importers: AXIM_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } axim_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (size_e'(size))
            SIZE_BYTE:  mis = 1'b0;
            SIZE_HALF:  mis = addr_lo[0];
            SIZE_WORD:  mis = |addr_lo[1:0];
            SIZE_DWORD: mis = |addr_lo;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
// Converts one CPU memory request into a single AXI-lite read or write
// transaction, then returns a one-cycle completion pulse. One transaction in
// flight at a time; every AXI output comes straight from a register.
//
// Optional feature: define AXIM_ALIGN_CHECK_EN to reject misaligned requests
// with an immediate error completion and no bus traffic.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    CPU request (valid/ready, wen, addr, size, wdata, wstrb)
//   resp_valid/rdata/err     completion pulse, read data, error flag
//   ar*/r*                   AXI read address and read data channels
//   aw*/w*/b*                AXI write address, write data, write response
// ---------------------------------------------------------------------------
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    axim_state_e          state_q;
    logic [ADDR_W-1:0]    araddr_q, awaddr_q;
    logic [DATA_W-1:0]    wdata_q, resp_rdata_q;
    logic [DATA_W/8-1:0]  wstrb_q;
    logic                 arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                 aw_done_q, w_done_q;
    logic                 resp_valid_q, resp_err_q;

    logic aw_hs, w_hs, misaligned;

    assign aw_hs = awvalid_q & awready;
    assign w_hs  = wvalid_q & wready;

`ifdef AXIM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_addr[2:0], req_size);
`else
    // Size only matters to the alignment check; without it every request goes out.
    logic unused_req_size;
    assign unused_req_size = ^req_size;
    assign misaligned      = 1'b0;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too, so the bus shows zeros
            // rather than stale data after a mid-transaction reset.
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // Completion is a single-cycle pulse.
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_wen) begin
                            awaddr_q  <= req_addr;
                            wdata_q   <= req_wdata;
                            wstrb_q   <= req_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            araddr_q  <= req_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata;
                        resp_err_q   <= (rresp != RESP_OKAY);
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W retire independently; the response phase opens
                    // once both have, counting a handshake happening right now.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= (bresp != RESP_OKAY);
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = awaddr_q;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench for axi_lite_master. A channel-obligation model (which AXI
// channel the master currently owes, which completion is due) is checked
// against the DUT on every falling edge; the directed tasks additionally pin
// hand-computed literal results. Honour AXIM_ALIGN_CHECK_EN the same way as
// the RTL build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]  wstrb;

    axi_lite_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: what the master owes on each channel ----------
    bit          started = 1'b0;
    bit          m_busy, m_ar, m_r, m_aw, m_w, m_wphase, m_b, m_resp;
    bit          m_err;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wstrb;
    int          aw_cnt = 0, w_cnt = 0;

    function automatic bit model_misaligned(input logic [31:0] a, input logic [1:0] s);
`ifdef AXIM_ALIGN_CHECK_EN
        return (a % (32'd1 << s)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("req_ready", req_ready, !m_busy);
            check("arvalid", arvalid, m_ar);
            check("rready", rready, m_r);
            check("awvalid", awvalid, m_aw);
            check("wvalid", wvalid, m_w);
            check("bready", bready, m_b);
            check("resp_valid", resp_valid, m_resp);
            if (m_ar) check("araddr", araddr, m_addr);
            if (m_aw) check("awaddr", awaddr, m_addr);
            if (m_w) begin
                check("wdata", wdata, m_wdata);
                check("wstrb", wstrb, m_wstrb);
            end
            if (m_resp) begin
                check("resp_err", resp_err, m_err);
                check("resp_rdata", resp_rdata, m_rdata);
            end
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
        end

        // Advance the model across the coming rising edge.
        m_resp = 1'b0;
        if (rst) begin
            {m_busy, m_ar, m_r, m_aw, m_w, m_wphase, m_b, m_err} = '0;
            m_rdata = '0;
        end else begin
            if (m_ar && arready) begin m_ar = 1'b0; m_r = 1'b1; end
            else if (m_r && rvalid) begin
                m_r = 1'b0; m_busy = 1'b0; m_resp = 1'b1;
                m_rdata = rdata; m_err = (rresp != 2'b00);
            end
            if (m_aw && awready) m_aw = 1'b0;
            if (m_w && wready) m_w = 1'b0;
            if (m_wphase && !m_aw && !m_w) begin m_wphase = 1'b0; m_b = 1'b1; end
            else if (m_b && bvalid) begin
                m_b = 1'b0; m_busy = 1'b0; m_resp = 1'b1; m_err = (bresp != 2'b00);
            end
            if (!m_busy && !m_resp && req_valid && started) begin
                if (model_misaligned(req_addr, req_size)) begin
                    m_resp = 1'b1; m_err = 1'b1; m_rdata = '0;
                end else begin
                    m_busy = 1'b1;
                    m_addr = req_addr;
                    if (req_wen) begin
                        m_aw = 1'b1; m_w = 1'b1; m_wphase = 1'b1;
                        m_wdata = req_wdata; m_wstrb = req_wstrb;
                    end else begin
                        m_ar = 1'b1;
                    end
                end
            end else if (!m_busy && m_resp && req_valid) begin
                // Completion cycle is also an idle cycle: accept back-to-back.
                m_busy = 1'b1;
                m_addr = req_addr;
                if (req_wen) begin
                    m_aw = 1'b1; m_w = 1'b1; m_wphase = 1'b1;
                    m_wdata = req_wdata; m_wstrb = req_wstrb;
                end else begin
                    m_ar = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present_req(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                               input logic [63:0] wd, input logic [7:0] ws);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_wdata = wd; req_wstrb = ws;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ar_handshake(input int dly);
        bit hs;
        int n;
        repeat (dly) step();
        arready = 1'b1;
        n = 0;
        do begin hs = arvalid; step(); n++; end while (!hs && n < 50);
        arready = 1'b0;
        check("ar_handshake_seen", hs, 1'b1);
    endtask

    task automatic r_handshake(input int dly, input logic [63:0] rd, input logic [1:0] rr);
        bit hs;
        int n;
        repeat (dly) step();
        rdata = rd; rresp = rr; rvalid = 1'b1;
        n = 0;
        do begin hs = rready; step(); n++; end while (!hs && n < 50);
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        check("r_handshake_seen", hs, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input int ar_dly,
                           input int r_dly, input logic [63:0] rd, input logic [1:0] rr,
                           input bit exp_err);
        present_req(1'b0, addr, size, '0, '0);
        check("rd_arvalid_at_n1", arvalid, 1'b1);
        check("rd_araddr_at_n1", araddr, addr);
        ar_handshake(ar_dly);
        r_handshake(r_dly, rd, rr);
        check("rd_resp_valid", resp_valid, 1'b1);
        check("rd_resp_rdata", resp_rdata, rd);
        check("rd_resp_err", resp_err, exp_err);
        check("rd_req_ready_m1", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws,
                            input int aw_dly, input int w_dly, input logic [1:0] br,
                            input bit exp_err, input logic [63:0] held_rdata);
        int t, n, aw0, w0;
        bit aw_hs, w_hs, a, w, hs;
        aw0 = aw_cnt; w0 = w_cnt;
        present_req(1'b1, addr, 2'd3, wd, ws);
        check("wr_awvalid_at_n1", awvalid, 1'b1);
        check("wr_wvalid_at_n1", wvalid, 1'b1);
        t = 0; aw_hs = 1'b0; w_hs = 1'b0;
        while (!(aw_hs && w_hs) && t < 50) begin
            awready = (t >= aw_dly) && !aw_hs;
            wready  = (t >= w_dly) && !w_hs;
            a = awready && awvalid;
            w = wready && wvalid;
            step();
            aw_hs |= a; w_hs |= w; t++;
        end
        awready = 1'b0; wready = 1'b0;
        check("wr_both_handshakes", {aw_hs, w_hs}, 2'b11);
        bresp = br; bvalid = 1'b1;
        n = 0;
        do begin hs = bready; step(); n++; end while (!hs && n < 50);
        bvalid = 1'b0; bresp = 2'b00;
        check("b_handshake_seen", hs, 1'b1);
        check("wr_resp_valid", resp_valid, 1'b1);
        check("wr_resp_err", resp_err, exp_err);
        check("wr_rdata_held", resp_rdata, held_rdata);
        check("wr_aw_count", aw_cnt - aw0, 1);
        check("wr_w_count", w_cnt - w0, 1);
    endtask

    // ---------------- directed sequence ------------------------------------
    initial begin
        rst = 1'b1;
        {req_valid, req_wen, arready, rvalid, awready, wready, bvalid} = '0;
        req_addr = '0; req_size = '0; req_wdata = '0; req_wstrb = '0;
        rdata = '0; rresp = '0; bresp = '0;
        {m_busy, m_ar, m_r, m_aw, m_w, m_wphase, m_b, m_resp, m_err} = '0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0;
        step();
        started = 1'b1;
        step();
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        step();

        // Plain read, arready immediate, rvalid two cycles after AR.
        do_read(32'h8000_0008, 2'd3, 0, 2, 64'h1122_3344_5566_7788, 2'b00, 1'b0);
        step();
        // Write with AW accepted 3 cycles before W; rdata must stay from the read.
        do_write(32'h8000_0010, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0, 3, 2'b00, 1'b0,
                 64'h1122_3344_5566_7788);
        step();
        // W before AW, then both in the same cycle.
        do_write(32'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'h0F, 2, 0, 2'b00, 1'b0,
                 64'h1122_3344_5566_7788);
        do_write(32'h8000_0020, 64'hCAFE_F00D_1234_5678, 8'hFF, 1, 1, 2'b00, 1'b0,
                 64'h1122_3344_5566_7788);
        step();
        // Error responses.
        do_read(32'h8000_0028, 2'd3, 1, 0, 64'h5555_AAAA_5555_AAAA, 2'b10, 1'b1);
        do_write(32'h8000_0030, 64'h1, 8'h01, 0, 0, 2'b11, 1'b1, 64'h5555_AAAA_5555_AAAA);
        step();
        // Back-to-back reads: second presented in the completion cycle.
        do_read(32'h8000_0040, 2'd3, 0, 0, 64'hFEDC_BA98_7654_3210, 2'b00, 1'b0);
        do_read(32'h8000_0048, 2'd3, 0, 1, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 1'b0);
        step();

        // Reset while waiting for read data.
        present_req(1'b0, 32'h8000_0050, 2'd3, '0, '0);
        ar_handshake(0);
        check("pre_rst_rready", rready, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_arvalid", arvalid, 1'b0);
        check("mid_rst_rready", rready, 1'b0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        repeat (4) step();

`ifdef AXIM_ALIGN_CHECK_EN
        // Misaligned word: no bus traffic, error completion at N+1.
        present_req(1'b0, 32'h8000_0002, 2'd2, '0, '0);
        check("mis_resp_valid", resp_valid, 1'b1);
        check("mis_resp_err", resp_err, 1'b1);
        check("mis_resp_rdata", resp_rdata, 64'h0);
        check("mis_arvalid", arvalid, 1'b0);
        check("mis_req_ready", req_ready, 1'b1);
        repeat (3) step();
        // Aligned half-word at the same address goes to the bus normally.
        do_read(32'h8000_0002, 2'd1, 0, 1, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00, 1'b0);
        repeat (2) step();
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
